// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for the RV32I datapath,
// with memory handshake timeouts, a retired-instruction counter and a sticky bus error.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 halt_req,
    input  logic                 imem_ack,
    output logic                 imem_req,
    output logic                 ir_load,
    input  logic                 en_jmp,
    input  logic                 en_uncond_jmp,
    input  logic                 en_rel_reg_jmp,
    input  logic                 en_reg_wr,
    input  logic                 en_mem_wr,
    input  logic                 dmem_addr_bus_use,
    input  logic [2:0]           ld_code,
    input  logic                 branch_taken,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 pc_load,
    output logic                 pc_sel,
    output logic                 reg_wr,
    output logic                 illegal,
    output logic                 err,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);
    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERR    = 3'd7
    } state_t;

    state_t        st;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            cnt     <= '0;
            err     <= 1'b0;
            instret <= '0;
        end else begin
            case (st)
                IDLE: if (run) begin
                    st  <= FETCH;
                    cnt <= '0;
                end
                // an ack on the threshold cycle still completes the fetch
                FETCH: if (imem_ack) st <= DECODE;
                    else if (cnt == TMAX) begin
                        st  <= ERR;
                        err <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                DECODE: st <= EXEC;
                EXEC: if (dmem_addr_bus_use) begin
                    st  <= MEM;
                    cnt <= '0;
                end else st <= WB;
                MEM: if (dmem_ack) st <= WB;
                    else if (cnt == TMAX) begin
                        st  <= ERR;
                        err <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                WB: begin
                    instret <= instret + 1'b1;
                    cnt     <= '0;
                    st      <= halt_req ? IDLE : FETCH;
                end
                ERR: err <= 1'b1;
                default: begin
                    st  <= ERR;
                    err <= 1'b1;
                end
            endcase
        end
    end

    assign state    = st;
    assign imem_req = st == FETCH;
    assign ir_load  = (st == FETCH) & imem_ack;
    assign dmem_req = st == MEM;
    assign dmem_we  = (st == MEM) & en_mem_wr;
    assign pc_load  = st == WB;
    assign pc_sel   = (st == WB) & en_jmp & (en_uncond_jmp | en_rel_reg_jmp | branch_taken);
    // branches carry en_reg_wr with ld_code 0 and must not write back
    assign reg_wr   = (st == WB) & en_reg_wr & (ld_code != 3'd0);
    assign illegal  = (st == WB) & ~(en_jmp | en_reg_wr | en_mem_wr | dmem_addr_bus_use);
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed bench with a writeback scoreboard for core_sequencer.
module tb_core_sequencer;
    localparam int IW = 4;

    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, halt_req = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic en_jmp = 1'b0, en_uncond_jmp = 1'b0, en_rel_reg_jmp = 1'b0, en_reg_wr = 1'b0;
    logic en_mem_wr = 1'b0, dmem_addr_bus_use = 1'b0, branch_taken = 1'b0;
    logic [2:0] ld_code = 3'd0;
    logic imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_sel, reg_wr, illegal, err;
    logic [2:0] state;
    logic [IW-1:0] instret;

    core_sequencer #(.MEM_TIMEOUT(16), .INSTRET_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .imem_ack(imem_ack), .imem_req(imem_req), .ir_load(ir_load),
        .en_jmp(en_jmp), .en_uncond_jmp(en_uncond_jmp), .en_rel_reg_jmp(en_rel_reg_jmp),
        .en_reg_wr(en_reg_wr), .en_mem_wr(en_mem_wr), .dmem_addr_bus_use(dmem_addr_bus_use),
        .ld_code(ld_code), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_load(pc_load), .pc_sel(pc_sel), .reg_wr(reg_wr), .illegal(illegal),
        .err(err), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ps;
        logic rw;
        logic il;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;
    logic [IW-1:0] m_ir = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; iw/dw are ack wait cycles.
    task automatic instr(input logic j, u, r, rw, mw, bus, input logic [2:0] ld, input logic bt,
                         input int iw, dw, input logic hlt, input logic eps, erw, eil);
        exp_t e;
        q.push_back('{eps, erw, eil});
        {en_jmp, en_uncond_jmp, en_rel_reg_jmp, en_reg_wr, en_mem_wr, dmem_addr_bus_use} = {j, u, r, rw, mw, bus};
        ld_code = ld;
        branch_taken = bt;
        for (int i = 0; i < iw; i++) begin
            imem_ack = 1'b0;
            #1 chk("fetch_state", state, 1);
            chk("fetch_req", imem_req, 1);
            chk("fetch_noload", ir_load, 0);
            tick();
        end
        imem_ack = 1'b1;
        #1 chk("fetch_ack_state", state, 1);
        chk("ir_load", ir_load, 1);
        tick();
        imem_ack = 1'b0;
        chk("decode_state", state, 2);
        chk("decode_noreq", imem_req, 0);
        tick();
        chk("exec_state", state, 3);
        chk("exec_nopc", pc_load, 0);
        tick();
        if (bus) begin
            for (int i = 0; i <= dw; i++) begin
                dmem_ack = (i == dw);
                #1 chk("mem_state", state, 4);
                chk("dmem_req", dmem_req, 1);
                chk("dmem_we", dmem_we, mw);
                tick();
            end
            dmem_ack = 1'b0;
        end
        halt_req = hlt;
        #1 chk("wb_state", state, 5);
        chk("wb_pc_load", pc_load, 1);
        chk("wb_dmem_idle", dmem_req, 0);
        if (q.size() == 0) chk("wb_queue", 0, 1);
        else begin
            e = q.pop_front();
            chk("wb_pc_sel", pc_sel, e.ps);
            chk("wb_reg_wr", reg_wr, e.rw);
            chk("wb_illegal", illegal, e.il);
        end
        tick();
        halt_req = 1'b0;
        m_ir = m_ir + 1'b1;
        chk("instret", instret, m_ir);
        chk("after_wb_state", state, hlt ? 0 : 1);
        chk("illegal_pulse", illegal, 0);
    endtask

    initial begin
        #12;
        chk("rst_state", state, 0);
        chk("rst_instret", instret, 0);
        chk("rst_err", err, 0);
        chk("rst_imem_req", imem_req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_hold", state, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        // ADDI, zero-wait fetch
        instr(0, 0, 0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 1, 0);
        // store with 3 dmem wait cycles
        instr(0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 3, 0, 0, 0, 0);
        // load, zero wait
        instr(0, 0, 0, 1, 0, 1, 3'b010, 0, 0, 0, 0, 0, 1, 0);
        // BEQ not taken, taken; JAL
        instr(1, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        instr(1, 0, 0, 1, 0, 0, 3'b000, 1, 0, 0, 0, 1, 0, 0);
        instr(1, 1, 0, 1, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, 0);
        instr(1, 0, 1, 1, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, 0);
        // undecodable instruction, then halt
        instr(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 1);
        imem_ack = 1'b1;
        tick();
        chk("halt_idle", state, 0);
        chk("halt_no_req", imem_req, 0);
        chk("idle_ignores_ack", ir_load, 0);
        imem_ack = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("resume_fetch", state, 1);
        // ack on the 16th fetch cycle beats the timeout
        instr(0, 0, 0, 1, 0, 0, 3'b001, 0, 15, 0, 0, 0, 1, 0);
        chk("late_ack_no_err", err, 0);
        // reset in the middle of a load's data handshake
        {en_jmp, en_reg_wr, dmem_addr_bus_use, ld_code} = {1'b0, 1'b1, 1'b1, 3'b010};
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        chk("pre_rst_mem", state, 4);
        chk("pre_rst_dmem_req", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_dmem_req", dmem_req, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_instret", instret, 0);
        m_ir = '0;
        tick();
        rst_n = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("post_rst_fetch", state, 1);
        // wrap the counter through retirements
        for (int k = 0; k < 16; k++) instr(0, 0, 0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 1, 0);
        chk("instret_wrap", instret, 0);
        // fetch that never completes
        for (int k = 0; k < 16; k++) begin
            chk("to_fetch_state", state, 1);
            chk("to_fetch_err", err, 0);
            tick();
        end
        chk("to_err_state", state, 7);
        chk("to_err_flag", err, 1);
        chk("to_err_imem_req", imem_req, 0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        tick();
        chk("err_sticky_state", state, 7);
        chk("err_sticky", err, 1);
        chk("err_no_load", ir_load, 0);
        chk("err_no_pc", pc_load, 0);
        chk("wb_queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the single-issue RV32I datapath through fetch, decode, execute, memory and writeback. It drives the instruction- and data-memory request/acknowledge handshakes, the instruction-register latch, the PC update and the register-file write strobe. It takes its per-instruction control from the instruction decoder's outputs. It also keeps a retired-instruction counter and a sticky bus-timeout error.

Parameters:
MEM_TIMEOUT, 16, max cycles a request waits for its ack before the block enters ERR (legal range 2..255)
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  start execution; sampled only in IDLE
halt_req  in  1  stop after the current instruction retires; sampled only in WB
imem_ack  in  1  instruction memory: data valid this cycle
imem_req  out  1  instruction fetch request
ir_load  out  1  latch instruction bus into the instruction register
en_jmp  in  1  decoder: control-transfer instruction
en_uncond_jmp  in  1  decoder: JAL
en_rel_reg_jmp  in  1  decoder: JALR
en_reg_wr  in  1  decoder: register write enable
en_mem_wr  in  1  decoder: store
dmem_addr_bus_use  in  1  decoder: load/store needs the data bus
ld_code  in  3  decoder: writeback source (000 = none)
branch_taken  in  1  ALU compare result, valid in EXEC and WB
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write qualifier
dmem_ack  in  1  data memory: access complete this cycle
pc_load  out  1  load a new value into PC
pc_sel  out  1  0 = PC+4, 1 = jump/branch target
reg_wr  out  1  register file write strobe
illegal  out  1  one-cycle pulse in WB for an undecodable instruction
err  out  1  sticky; set when the block enters ERR
state  out  3  current state code
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7; state 6 is unused and maps to ERR.
- Reset (async, any time, including mid-handshake):
  - state=IDLE, instret=0, err=0, timeout counter=0.
  - All strobe outputs drop to 0 immediately, with no clock needed.
  - An in-flight memory request is abandoned.
- All strobe outputs are Moore/Mealy combinational from state and inputs; there are no registered strobes.
- IDLE: all strobes 0. Go to FETCH on run=1.
- FETCH:
  - imem_req=1 every cycle in this state.
  - On a cycle with imem_ack=1: ir_load=1 in that same cycle, next state DECODE.
  - Without ack, the timeout counter increments. When it equals MEM_TIMEOUT-1 and ack is still low, next state is ERR.
- DECODE: exactly 1 cycle with no strobes (decoder settles). Next state EXEC.
- EXEC: exactly 1 cycle with no strobes. Next state MEM if dmem_addr_bus_use=1, else WB.
- MEM:
  - dmem_req=1 and dmem_we=en_mem_wr, held until dmem_ack=1.
  - On ack, next state WB.
  - Timeout rule identical to FETCH.
- Timeout counter: cleared on every entry to FETCH or MEM; width is ceil(log2(MEM_TIMEOUT)).
- WB (exactly 1 cycle):
  - pc_load=1.
  - pc_sel = en_jmp & (en_uncond_jmp | en_rel_reg_jmp | branch_taken).
  - reg_wr = en_reg_wr & (ld_code != 0). Branches have en_reg_wr=1 with ld_code=0, so they must not write.
  - illegal=1 when en_jmp, en_reg_wr, en_mem_wr and dmem_addr_bus_use are all 0; PC still advances by 4.
  - instret increments by 1 and wraps from all-ones to 0.
  - Next state IDLE if halt_req=1, else FETCH.
- ERR: err=1; all strobes 0. Leaves only through reset.
- An ack arriving in the same cycle as the timeout threshold wins: the handshake completes and the block does not enter ERR.
- Acks in any state other than the one waiting for them are ignored.
- Cycle counts with zero-wait memory (ack on the first request cycle):
  - Non-memory instruction: 4 cycles.
  - Load/store: 5 cycles.

Test Plan:
- Reset, run=1, ADDI (ld_code=001, en_reg_wr=1), imem_ack on the first cycle -> states 1,2,3,5,1; reg_wr=1 and pc_sel=0 in WB; instret=1.
- Store (en_mem_wr=1, dmem_addr_bus_use=1, ld_code=0), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles with dmem_we=1; reg_wr=0 in WB; 8 cycles total.
- BEQ (en_jmp=1, en_reg_wr=1, ld_code=0): branch_taken=0 -> pc_sel=0, reg_wr=0. branch_taken=1 -> pc_sel=1. JAL with branch_taken=0 -> pc_sel=1, reg_wr=1.
- imem_ack never asserted, MEM_TIMEOUT=16 -> enters ERR after 16 FETCH cycles; err=1, imem_req=0. Ack on the 16th cycle instead -> DECODE, err=0.
- rst_n low during MEM with dmem_req=1 -> dmem_req=0 immediately, state=0, instret=0. halt_req=1 in WB -> IDLE; run=1 resumes in FETCH.
- Decoder all zero -> illegal pulse 1 cycle, pc_load=1, pc_sel=0. Preload instret=2^32-1 through retirements (or a forced value) -> wraps to 0.
